// File: rtl/pixel_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_scanner
//  Purpose  : Walks a frame in row-major order and issues one fixed-point
//             screen coordinate per permitted cycle to a ray pipeline. It
//             limits the number of rays in flight and tracks which pixel
//             each in-order result belongs to. It pulses frame_done when
//             the last pixel of the frame returns.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start               - one-cycle frame request (accepted in IDLE)
//             issue_enable        - downstream can accept a coordinate
//             result_valid        - one completed pixel returns this cycle
//             screen_x/screen_y   - registered 16.16 coordinate of the issue
//             coords_valid        - screen_x/screen_y valid this cycle
//             result_px/result_py - pixel that result_valid belongs to
//             busy                - frame in progress (SCAN or DRAIN)
//             frame_done          - one-cycle pulse after the last return
//             frame_cycles        - only with PIXEL_SCANNER_STATS_EN defined
//  Config   : `define PIXEL_SCANNER_STATS_EN adds the frame_cycles counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_scanner #(
    parameter int        H_RES        = 640,
    parameter int        V_RES        = 480,
    parameter int        MAX_INFLIGHT = 16,
    parameter int signed X_START      = -87381,
    parameter int signed X_STEP       = 273,
    parameter int signed Y_START      = 65536,
    parameter int signed Y_STEP       = 273,
    localparam int       c_PX_W       = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int       c_PY_W       = (V_RES > 1) ? $clog2(V_RES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              issue_enable,
    input  logic              result_valid,
    output logic [31:0]       screen_x,
    output logic [31:0]       screen_y,
    output logic              coords_valid,
    output logic [c_PX_W-1:0] result_px,
    output logic [c_PY_W-1:0] result_py,
    output logic              busy,
    output logic              frame_done
`ifdef PIXEL_SCANNER_STATS_EN
    ,
    output logic [31:0]       frame_cycles
`endif
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SCAN  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    localparam logic [c_PX_W-1:0] c_COL_LAST = c_PX_W'(H_RES - 1);
    localparam logic [c_PY_W-1:0] c_ROW_LAST = c_PY_W'(V_RES - 1);
    localparam logic [7:0]        c_MAX_INF  = 8'(MAX_INFLIGHT);
    localparam logic [31:0]       c_X_START  = 32'(X_START);
    localparam logic [31:0]       c_X_STEP   = 32'(X_STEP);
    localparam logic [31:0]       c_Y_START  = 32'(Y_START);
    localparam logic [31:0]       c_Y_STEP   = 32'(Y_STEP);

    logic [1:0]        r_state;
    logic [c_PX_W-1:0] r_col;
    logic [c_PY_W-1:0] r_row;
    logic [31:0]       r_x_acc;
    logic [31:0]       r_y_acc;
    logic [7:0]        r_inflight;
    logic [c_PX_W-1:0] r_ret_px;
    logic [c_PY_W-1:0] r_ret_py;
    logic [31:0]       r_screen_x;
    logic [31:0]       r_screen_y;
    logic              r_coords_valid;
    logic              r_frame_done;

    logic w_issue;
    logic w_issue_last;
    logic w_ret;
    logic w_ret_last;

    assign w_issue      = (r_state == c_ST_SCAN) && issue_enable && (r_inflight < c_MAX_INF);
    assign w_issue_last = w_issue && (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
    // A return with nothing outstanding is stale (e.g. left over from an
    // aborted frame) and must not move the counters or underflow inflight.
    assign w_ret        = result_valid && ((r_inflight != 8'd0) || w_issue);
    assign w_ret_last   = w_ret && (r_state == c_ST_DRAIN) &&
                          (r_ret_px == c_COL_LAST) && (r_ret_py == c_ROW_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_col          <= '0;
            r_row          <= '0;
            r_x_acc        <= c_X_START;
            r_y_acc        <= c_Y_START;
            r_inflight     <= 8'd0;
            r_ret_px       <= '0;
            r_ret_py       <= '0;
            r_screen_x     <= 32'd0;
            r_screen_y     <= 32'd0;
            r_coords_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_coords_valid <= 1'b0;
            r_frame_done   <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_SCAN;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_x_acc <= c_X_START;
                        r_y_acc <= c_Y_START;
                    end
                end
                c_ST_SCAN: begin
                    if (w_issue) begin
                        r_coords_valid <= 1'b1;
                        r_screen_x     <= r_x_acc;
                        r_screen_y     <= r_y_acc;
                        if (r_col != c_COL_LAST) begin
                            r_col   <= r_col + 1'b1;
                            r_x_acc <= r_x_acc + c_X_STEP;
                        end else begin
                            // Rows descend in y: screen top is the largest y.
                            r_col   <= '0;
                            r_x_acc <= c_X_START;
                            r_row   <= r_row + 1'b1;
                            r_y_acc <= r_y_acc - c_Y_STEP;
                        end
                        if (w_issue_last) begin
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_ret_last) begin
                        r_frame_done <= 1'b1;
                        r_state      <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            // Simultaneous issue and return cancel out.
            if (w_issue && !w_ret) begin
                r_inflight <= r_inflight + 8'd1;
            end else if (w_ret && !w_issue) begin
                r_inflight <= r_inflight - 8'd1;
            end

            // Results come back in issue order, so a plain row-major counter
            // identifies each returning pixel.
            if (w_ret) begin
                if (w_ret_last) begin
                    r_ret_px <= '0;
                    r_ret_py <= '0;
                end else if (r_ret_px != c_COL_LAST) begin
                    r_ret_px <= r_ret_px + 1'b1;
                end else begin
                    r_ret_px <= '0;
                    r_ret_py <= r_ret_py + 1'b1;
                end
            end
        end
    end

    assign screen_x     = r_screen_x;
    assign screen_y     = r_screen_y;
    assign coords_valid = r_coords_valid;
    assign result_px    = r_ret_px;
    assign result_py    = r_ret_py;
    assign busy         = (r_state != c_ST_IDLE);
    assign frame_done   = r_frame_done;

`ifdef PIXEL_SCANNER_STATS_EN
    logic [31:0] r_cyc;
    logic [31:0] r_frame_cycles;
    logic [31:0] w_cyc_inc;

    // Saturating increment so a stalled frame never wraps back to small counts.
    assign w_cyc_inc = (r_cyc == 32'hFFFF_FFFF) ? r_cyc : r_cyc + 32'd1;

    // r_cyc counts edges since leaving IDLE; the done edge itself is included
    // by latching the incremented value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc          <= 32'd0;
            r_frame_cycles <= 32'd0;
        end else if (r_state == c_ST_IDLE) begin
            if (start) begin
                r_cyc <= 32'd0;
            end
        end else begin
            r_cyc <= w_cyc_inc;
            if (w_ret_last) begin
                r_frame_cycles <= w_cyc_inc;
            end
        end
    end

    assign frame_cycles = r_frame_cycles;
`endif

endmodule
`default_nettype wire
